// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and transmitter.
// Holds the FSM state encodings, the legal baud-counter range and the bit-period derivation.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START_BIT,
        RX_DATA_BITS,
        RX_STOP_BIT,
        RX_WAIT_IDLE
    } rxState_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START_BIT,
        TX_DATA_BITS,
        TX_STOP_BIT
    } txState_t;

    // The baud counter is 16 bits wide.
    // Below 8 clocks per bit the mid-point and majority window collapse into each other.
    localparam int unsigned TIMER_MIN = 8;
    localparam int unsigned TIMER_MAX = 65535;

    // Clocks per serial bit, truncated.
    function automatic int unsigned timerCount(input int unsigned sysClock,
                                               input int unsigned baudRate);
        return sysClock / baudRate;
    endfunction

    // Clocks from a bit edge to its mid-point.
    function automatic int unsigned halfCount(input int unsigned timer);
        return timer / 2;
    endfunction

endpackage

// File: rtl/uart_baud_timer.sv
// Baud timer: 16-bit up-counter that marks the half-period and the full period.
// It wraps to zero on the full period, so consecutive full ticks are exactly one bit apart.
module uart_baud_timer
    import uart_pkg::*;
#(
    parameter int unsigned TIMER_COUNT = 434
)(
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic halfTick,
    output logic fullTick
);

    localparam logic [15:0] FULL_LAST = 16'(TIMER_COUNT - 1);
    localparam logic [15:0] HALF_LAST = 16'(halfCount(TIMER_COUNT) - 1);

    logic [15:0] count;
    logic        atFull;
    logic        atHalf;

    // Decode the terminal counts; ticks are only meaningful while counting.
    always_comb begin
        atFull   = (count == FULL_LAST);
        atHalf   = (count == HALF_LAST);
        fullTick = enable & atFull;
        halfTick = enable & atHalf;
    end

    // Count while enabled; clear restarts the period from zero.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= atFull ? '0 : count + 16'd1;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1, LSB first.
// The line is brought into the clock domain through a 2-flop synchronizer.
// A falling edge starts a frame. The start bit is re-checked at its mid-point.
// Data and stop bits are then sampled one bit period apart.
// Optional macro UART_RX_MAJORITY_EN: each sample becomes a 2-of-3 vote over mid-1/mid/mid+1.
// With the macro, decisions land one clock later.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned SYS_CLOCK     = 50000000,
    parameter int unsigned UART_BAUDRATE = 115200
)(
    input  logic       i_SysClock,
    input  logic       i_Reset,
    input  logic       i_RxSerial,
    output logic [7:0] o_RxByte,
    output logic       o_RxValid,
    output logic       o_FrameErr
);

    localparam int unsigned TIMER_COUNT = timerCount(SYS_CLOCK, UART_BAUDRATE);

    generate
        if (TIMER_COUNT < TIMER_MIN || TIMER_COUNT > TIMER_MAX) begin : g_badTimer
            $error("uart_rx: SYS_CLOCK/UART_BAUDRATE must lie in 8..65535");
        end
    endgenerate

    rxState_t   state;
    rxState_t   nextState;
    logic       rxSync_p0;
    logic       rxSync_p1;
    logic       rxHist_p2;
    logic [2:0] bitIdx;
    logic [7:0] shiftReg;
    logic       timerEn;
    logic       timerClear;
    logic       halfTick;
    logic       fullTick;
    logic       tickNow;
    logic       strobe;
    logic       sampleBit;
    logic       shiftEn;
    logic       loadByte;
    logic       frameErr;

    uart_baud_timer #(
        .TIMER_COUNT(TIMER_COUNT)
    ) baudTimer (
        .clk     (i_SysClock),
        .rst     (i_Reset),
        .enable  (timerEn),
        .clear   (timerClear),
        .halfTick(halfTick),
        .fullTick(fullTick)
    );

    // Synchronize the line and keep one more delayed copy for falling-edge detection.
    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            rxSync_p0 <= 1'b1;
            rxSync_p1 <= 1'b1;
            rxHist_p2 <= 1'b1;
        end else begin
            rxSync_p0 <= i_RxSerial;
            rxSync_p1 <= rxSync_p0;
            rxHist_p2 <= rxSync_p1;
        end
    end

    // The timer runs only inside a frame.
    // The start bit waits half a period; later bits wait full periods.
    always_comb begin
        timerEn = (state == RX_START_BIT) || (state == RX_DATA_BITS) || (state == RX_STOP_BIT);
        tickNow = (state == RX_START_BIT) ? halfTick : fullTick;
    end

`ifdef UART_RX_MAJORITY_EN
    logic rxHist_p3;
    logic tickDly;

    // Hold one more line sample, and delay the tick so the vote can include mid+1.
    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            rxHist_p3 <= 1'b1;
            tickDly   <= 1'b0;
        end else begin
            rxHist_p3 <= rxHist_p2;
            tickDly   <= tickNow;
        end
    end

    // Vote over the line at mid-1, mid and mid+1, and decide one clock after the mid-point.
    always_comb begin
        strobe    = tickDly;
        sampleBit = (rxHist_p3 & rxHist_p2) | (rxHist_p3 & rxSync_p1) | (rxHist_p2 & rxSync_p1);
    end
`else
    // Take a single sample at the mid-point.
    always_comb begin
        strobe    = tickNow;
        sampleBit = rxSync_p1;
    end
`endif

    // State register.
    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            state <= RX_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic and the per-cycle control strobes for the datapath.
    always_comb begin
        nextState  = state;
        timerClear = 1'b0;
        shiftEn    = 1'b0;
        loadByte   = 1'b0;
        frameErr   = 1'b0;
        unique case (state)
            RX_IDLE: begin
                if (rxHist_p2 && !rxSync_p1) begin
                    nextState  = RX_START_BIT;
                    timerClear = 1'b1;
                end
            end
            RX_START_BIT: begin
                // Re-zero at the start mid-point so each data sample lands a whole period later.
                timerClear = halfTick;
                if (strobe) begin
                    nextState = sampleBit ? RX_IDLE : RX_DATA_BITS;
                end
            end
            RX_DATA_BITS: begin
                if (strobe) begin
                    shiftEn = 1'b1;
                    if (bitIdx == 3'd7) begin
                        nextState = RX_STOP_BIT;
                    end
                end
            end
            RX_STOP_BIT: begin
                // Leave at the stop mid-point so a back-to-back start edge is still caught.
                if (strobe) begin
                    if (sampleBit) begin
                        loadByte  = 1'b1;
                        nextState = RX_IDLE;
                    end else begin
                        frameErr  = 1'b1;
                        nextState = RX_WAIT_IDLE;
                    end
                end
            end
            RX_WAIT_IDLE: begin
                if (rxSync_p1) begin
                    nextState = RX_IDLE;
                end
            end
            default: nextState = RX_IDLE;
        endcase
    end

    // Shift data in LSB first, publish the byte on a good stop, and pulse the flags.
    always_ff @(posedge i_SysClock) begin
        if (i_Reset) begin
            bitIdx     <= 3'd0;
            shiftReg   <= 8'h00;
            o_RxByte   <= 8'h00;
            o_RxValid  <= 1'b0;
            o_FrameErr <= 1'b0;
        end else begin
            o_RxValid  <= loadByte;
            o_FrameErr <= frameErr;
            if (shiftEn) begin
                shiftReg <= {sampleBit, shiftReg[7:1]};
                bitIdx   <= bitIdx + 3'd1;
            end
            if (loadByte) begin
                o_RxByte <= shiftReg;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx.
// Frames are driven cycle by cycle onto the serial line.
// A frame-level model predicts one event per frame: a good byte, or a framing error.
// A negedge monitor collects the pulses the receiver actually produces.
module tb_uart_rx;

    localparam int unsigned SYS_CLOCK = 50000000;
    localparam int unsigned BAUD      = 115200;
    localparam int T       = SYS_CLOCK / BAUD;
    localparam int HALF    = T / 2;
    localparam int LAT_MIN = HALF + 9 * T;
    localparam int LAT_MAX = HALF + 9 * T + 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] rxByte;
    logic       rxValid;
    logic       frameErr;

    uart_rx #(
        .SYS_CLOCK    (SYS_CLOCK),
        .UART_BAUDRATE(BAUD)
    ) dut (
        .i_SysClock(clk),
        .i_Reset   (rst),
        .i_RxSerial(rx),
        .o_RxByte  (rxByte),
        .o_RxValid (rxValid),
        .o_FrameErr(frameErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         isErr;
        logic [7:0] data;
        int         cyc;
    } evt_t;

    evt_t       expQ[$];
    evt_t       gotQ[$];
    int         nChecks   = 0;
    int         nFails    = 0;
    int         cyc       = 0;
    int         holdErrs  = 0;
    int         bothErrs  = 0;
    logic [7:0] prevByte  = 8'h00;
    logic       rstQ      = 1'b1;
    logic [7:0] modelByte = 8'h00;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        rstQ <= rst;
    end

    always @(negedge clk) begin
        if (rxValid && frameErr) bothErrs++;
        if (rxValid)  gotQ.push_back(evt_t'{isErr: 1'b0, data: rxByte, cyc: cyc});
        if (frameErr) gotQ.push_back(evt_t'{isErr: 1'b1, data: 8'h00, cyc: cyc});
        if (!rxValid && !rstQ && rxByte !== prevByte) holdErrs++;
        prevByte = rxByte;
    end

    task automatic idle(input logic lvl, input int n);
        for (int i = 0; i < n; i++) begin
            rx = lvl;
            @(negedge clk);
        end
    endtask

    // Drive one 10-bit frame.
    // glitch inverts the line for one clock at each data mid-point.
    // doReset pulses reset in the middle of data bit 4.
    task automatic sendFrame(input logic [7:0] d, input bit goodStop, input bit glitch,
                             input bit doReset);
        int   s;
        int   p;
        logic v;
        s = cyc;
        if (doReset) begin
            modelByte = 8'h00;
        end else begin
            expQ.push_back(evt_t'{isErr: !goodStop, data: goodStop ? d : 8'h00, cyc: s});
            if (goodStop) modelByte = d;
        end
        for (int j = 0; j < 10 * T; j++) begin
            p = j / T;
            if (p == 0)      v = 1'b0;
            else if (p <= 8) v = d[p-1];
            else             v = goodStop;
            if (glitch && p >= 1 && p <= 8 && j == HALF + p * T) v = ~v;
            rx  = v;
            rst = doReset && (j == 5 * T + HALF);
            @(negedge clk);
        end
        rst = 1'b0;
    endtask

    task automatic compareEvents(input string tag);
        int n;
        int lat;
        n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
        checkEq({tag, "/count"}, 32'(gotQ.size()), 32'(expQ.size()));
        for (int i = 0; i < n; i++) begin
            checkEq({tag, "/kind"}, 32'(gotQ[i].isErr), 32'(expQ[i].isErr));
            checkEq({tag, "/data"}, 32'(gotQ[i].data), 32'(expQ[i].data));
            lat = gotQ[i].cyc - expQ[i].cyc;
            checkEq({tag, "/latency"}, 32'((lat >= LAT_MIN && lat <= LAT_MAX) ? LAT_MIN : lat),
                    32'(LAT_MIN));
        end
        gotQ.delete();
        expQ.delete();
    endtask

    initial begin
        int         gap;
        logic [7:0] d;
        bit         good;

        rst = 1'b1;
        rx  = 1'b1;
        repeat (5) @(negedge clk);
        checkEq("reset/byte",  32'(rxByte),   32'h00);
        checkEq("reset/valid", 32'(rxValid),  32'h0);
        checkEq("reset/ferr",  32'(frameErr), 32'h0);
        rst = 1'b0;
        idle(1'b1, 20);

        // Single good frame
        sendFrame(8'h55, 1'b1, 1'b0, 1'b0);
        idle(1'b1, T);
        compareEvents("f55");
        checkEq("f55/byte", 32'(rxByte), 32'(modelByte));

        // Back-to-back frames with no idle gap
        sendFrame(8'hA3, 1'b1, 1'b0, 1'b0);
        sendFrame(8'h0F, 1'b1, 1'b0, 1'b0);
        idle(1'b1, T);
        checkEq("b2b/count", 32'(gotQ.size()), 32'd2);
        if (gotQ.size() >= 2) begin
            gap = gotQ[1].cyc - gotQ[0].cyc;
            checkEq("b2b/gap", 32'((gap >= 10 * T - 2 && gap <= 10 * T + 2) ? 10 * T : gap),
                    32'(10 * T));
        end
        compareEvents("b2b");
        checkEq("b2b/byte", 32'(rxByte), 32'(modelByte));

        // 100-clock low glitch: false start, then a frame 222 clocks after the glitch began
        idle(1'b0, 100);
        idle(1'b1, 122);
        compareEvents("glitch");
        sendFrame(8'h5A, 1'b1, 1'b0, 1'b0);
        idle(1'b1, T);
        compareEvents("postGlitch");
        checkEq("postGlitch/byte", 32'(rxByte), 32'(modelByte));

        // Low stop bit, line held low, then recovery
        sendFrame(8'hC8, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 3 * T);
        checkEq("ferr/byteHeld", 32'(rxByte), 32'(modelByte));
        idle(1'b1, T);
        sendFrame(8'h12, 1'b1, 1'b0, 1'b0);
        idle(1'b1, T);
        compareEvents("ferr");
        checkEq("ferr/byte", 32'(rxByte), 32'(modelByte));

        // Reset in the middle of a frame
        sendFrame(8'hFF, 1'b1, 1'b0, 1'b1);
        idle(1'b1, T);
        compareEvents("abort");
        checkEq("abort/byte", 32'(rxByte), 32'h00);
        sendFrame(8'h3C, 1'b1, 1'b0, 1'b0);
        idle(1'b1, T);
        compareEvents("afterReset");
        checkEq("afterReset/byte", 32'(rxByte), 32'h3C);

`ifdef UART_RX_MAJORITY_EN
        // One-clock glitches at every data mid-point are voted out
        sendFrame(8'h96, 1'b1, 1'b1, 1'b0);
        idle(1'b1, T);
        compareEvents("majority");
        checkEq("majority/byte", 32'(rxByte), 32'h96);
`endif

        // Random frames, mostly good, with random gaps
        for (int k = 0; k < 5; k++) begin
            d    = 8'($urandom);
            good = ($urandom_range(0, 3) != 0);
            sendFrame(d, good, 1'b0, 1'b0);
            if (!good)                          idle(1'b1, T);
            else if ($urandom_range(0, 1) != 0) idle(1'b1, HALF);
        end
        idle(1'b1, T);
        compareEvents("rand");
        checkEq("rand/byte", 32'(rxByte), 32'(modelByte));

        checkEq("holdBetweenPulses", 32'(holdErrs), 32'd0);
        checkEq("exclusivePulses",   32'(bothErrs), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
